// File: rtl/pea_pkg.sv
// Shared fetch/write-side definitions: FSM state codes and the log2 rule.
package pea_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    WAIT  = ST_WAIT,
    WRITE = ST_WRITE,
    DONE  = ST_DONE,
    ERR   = ST_ERR
  } fetch_state_e;

  // Address width for a depth; a depth of 1 still needs one bit.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mem_fetch_controller.sv
// Reads a run of RAM tokens and pushes them one at a time into the output FIFO.
// Optional FETCH_BOUND_CHECK_EN rejects requests that run past wr_limit.
module mem_fetch_controller
  import pea_pkg::*;
#(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  localparam int A = log2(buffer_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic [A-1:0]         base_addr,
  input  logic [A:0]           count,
  input  logic [A-1:0]         wr_limit,
  input  logic [word_size-1:0] ram_rd_data,
  input  logic [A:0]           fifo_free,
  output logic                 ram_rd_en,
  output logic [A-1:0]         ram_rd_addr,
  output logic                 fifo_wr_en,
  output logic [word_size-1:0] output_token,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out
);

  fetch_state_e   state;
  logic [A-1:0]   addr;
  logic [A-1:0]   addr_nxt;
  logic [A:0]     remaining;
  logic           bound_fail;
  logic           err_q;
  logic           last_tok;
  logic           has_room;

  assign addr_nxt = (addr == A'(buffer_size - 1))
                  ? '0 : addr + A'(1);
  assign last_tok = (remaining == {{A{1'b0}}, 1'b1});
  assign has_room = (fifo_free != '0);

`ifdef FETCH_BOUND_CHECK_EN
  logic [A+1:0] bound_end;
  assign bound_end  = {2'b00, base_addr} + {1'b0, count};
  assign bound_fail = bound_end > {2'b00, wr_limit};
  assign error_out  = err_q;
`else
  logic unused_ok;
  assign bound_fail = 1'b0;
  assign error_out  = 1'b0;
  assign unused_ok  = ^{wr_limit, err_q};
`endif

  // Strobe follows FIFO room in the same cycle so a stall costs no read.
  assign ram_rd_en   = (state == READ) && has_room;
  assign ram_rd_addr = addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      fifo_wr_en   <= 1'b0;
      output_token <= '0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      done_out   <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            busy_out <= 1'b1;
            if (count == '0) begin
              state    <= DONE;
              done_out <= 1'b1;
            end else if (bound_fail) begin
              state <= ERR;
              err_q <= 1'b1;
            end else begin
              state     <= READ;
              addr      <= base_addr;
              remaining <= count;
            end
          end
        end
        READ: begin
          if (has_room) state <= WAIT;
        end
        WAIT: begin
          output_token <= ram_rd_data;
          fifo_wr_en   <= 1'b1;
          state        <= WRITE;
        end
        WRITE: begin
          remaining <= remaining - {{A{1'b0}}, 1'b1};
          addr      <= addr_nxt;
          if (last_tok) begin
            state    <= DONE;
            done_out <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        DONE, ERR: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fetch_controller.sv
// Directed bench for mem_fetch_controller: transaction scoreboard plus
// hand-computed cycle and token expectations.
module tb_mem_fetch_controller;

  localparam int W  = 16;
  localparam int BS = 1024;
  localparam int A  = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_in = 1'b0;
  logic [A-1:0] base_addr = '0;
  logic [A:0]   count = '0;
  logic [A-1:0] wr_limit = 10'd1023;
  logic [W-1:0] ram_rd_data = '0;
  logic [A:0]   fifo_free = 11'd16;
  logic         ram_rd_en;
  logic [A-1:0] ram_rd_addr;
  logic         fifo_wr_en;
  logic [W-1:0] output_token;
  logic         busy_out;
  logic         done_out;
  logic         error_out;

  always #5 clk = ~clk;

  mem_fetch_controller #(
    .word_size(W),
    .buffer_size(BS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_in(start_in),
    .base_addr(base_addr),
    .count(count),
    .wr_limit(wr_limit),
    .ram_rd_data(ram_rd_data),
    .fifo_free(fifo_free),
    .ram_rd_en(ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .fifo_wr_en(fifo_wr_en),
    .output_token(output_token),
    .busy_out(busy_out),
    .done_out(done_out),
    .error_out(error_out)
  );

  logic [W-1:0] mem [BS];

  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  int ncount = 0;
  int start_neg = 0;
  int rd_cnt = 0;
  int done_cyc = -1;
  int err_cyc = -1;
  int exp_done = 0;
  int exp_err = 0;

  logic [A-1:0] exp_addr[$];
  logic [W-1:0] exp_tok[$];
  logic [A-1:0] rd_log[$];
  logic [W-1:0] tok_log[$];
  int           wr_cyc[$];
  logic         busy_log[$];

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input int b, input int c);
    for (int i = 0; i < c; i++) begin
      logic [A-1:0] a;
      a = A'((b + i) % BS);
      exp_addr.push_back(a);
      exp_tok.push_back(mem[a]);
    end
    exp_done++;
  endtask

  task automatic do_start(input int b, input int c);
    @(negedge clk);
    #1;
    start_in  = 1'b1;
    base_addr = A'(b);
    count     = (A+1)'(c);
    @(posedge clk);
    #1;
    start_in  = 1'b0;
    start_neg = ncount;
    rd_cnt    = 0;
    done_cyc  = -1;
    err_cyc   = -1;
    rd_log.delete();
    tok_log.delete();
    wr_cyc.delete();
    busy_log.delete();
  endtask

  task automatic wait_end();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy_out) break;
    end
    chk(!busy_out, "busy_timeout", busy_out, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_timing(input int n);
    chk(wr_cyc.size() == n, "wr_count", wr_cyc.size(), n);
    for (int i = 0; i < wr_cyc.size(); i++)
      chk(wr_cyc[i] == 3 * (i + 1), "wr_cycle", wr_cyc[i], 3 * (i + 1));
    chk(done_cyc == 3 * n + 1, "done_cycle", done_cyc, 3 * n + 1);
    chk(exp_addr.size() == 0 && exp_tok.size() == 0 && exp_done == 0,
        "model_drained", exp_addr.size() + exp_tok.size(), 0);
  endtask

  // Scoreboard: every read, write and pulse is matched against the model.
  always @(negedge clk) begin
    logic [A-1:0] ea;
    logic [W-1:0] et;
    ncount++;
    busy_log.push_back(busy_out);
    if (!rst) begin
      chk({ram_rd_en, fifo_wr_en, busy_out, done_out, error_out} == 5'b0
          && ram_rd_addr == '0 && output_token == '0,
          "reset_outputs",
          {ram_rd_en, fifo_wr_en, busy_out, done_out, error_out}, 0);
    end else begin
      if (ram_rd_en) begin
        rd_cnt++;
        rd_log.push_back(ram_rd_addr);
        if (exp_addr.size() == 0) begin
          chk(1'b0, "unexpected_read", ram_rd_addr, 0);
        end else begin
          ea = exp_addr.pop_front();
          chk(ram_rd_addr == ea && fifo_free != '0, "read_addr",
              ram_rd_addr, ea);
        end
      end
      if (fifo_wr_en) begin
        wr_cyc.push_back(ncount - start_neg);
        tok_log.push_back(output_token);
        if (exp_tok.size() == 0) begin
          chk(1'b0, "unexpected_write", output_token, 0);
        end else begin
          et = exp_tok.pop_front();
          chk(output_token == et, "token", output_token, et);
        end
      end
      if (done_out) begin
        done_cyc = ncount - start_neg;
        chk(exp_done > 0 && exp_addr.size() == 0 && exp_tok.size() == 0,
            "done_pulse", exp_tok.size(), 0);
        if (exp_done > 0) exp_done--;
      end
      if (error_out) begin
        err_cyc = ncount - start_neg;
        chk(exp_err > 0 && rd_cnt == 0, "error_pulse", rd_cnt, 0);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < BS; i++) mem[i] = W'(i * 37 + 16'h5A00);
    mem[4] = 16'h00A1;
    mem[5] = 16'h00B2;
    mem[6] = 16'h00C3;

    #12;
    chk({ram_rd_en, fifo_wr_en, busy_out, done_out, error_out} == 5'b0
        && ram_rd_addr == '0 && output_token == '0, "reset_state",
        {ram_rd_en, fifo_wr_en, busy_out, done_out, error_out}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // three-token fetch, no stalls
    expect_fetch(4, 3);
    do_start(4, 3);
    wait_end();
    check_timing(3);
    chk(wr_cyc.size() == 3 && wr_cyc[0] == 3 && wr_cyc[1] == 6
        && wr_cyc[2] == 9, "lit_wr_cycles", wr_cyc.size(), 3);
    chk(tok_log.size() == 3 && tok_log[0] == 16'hA1
        && tok_log[1] == 16'hB2 && tok_log[2] == 16'hC3,
        "lit_tokens", tok_log.size(), 3);
    chk(done_cyc == 10, "lit_done", done_cyc, 10);

    // zero-length request
    exp_done = 1;
    do_start(50, 0);
    wait_end();
    chk(done_cyc == 1, "zero_done", done_cyc, 1);
    chk(rd_cnt == 0 && wr_cyc.size() == 0, "zero_idle", rd_cnt, 0);
    chk(busy_log.size() >= 2 && busy_log[1] == 1'b0, "zero_busy_low",
        busy_log.size(), 2);

    // FIFO full stall in READ
    fifo_free = '0;
    expect_fetch(20, 2);
    do_start(20, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(!ram_rd_en, "stall_no_read", ram_rd_en, 0);
    end
    @(posedge clk);
    #1;
    fifo_free = 11'd1;
    @(negedge clk);
    chk(ram_rd_en && ram_rd_addr == 10'd20, "stall_release",
        ram_rd_addr, 20);
    wait_end();
    fifo_free = 11'd16;
    chk(tok_log.size() == 2 && tok_log[0] == mem[20]
        && tok_log[1] == mem[21], "stall_tokens", tok_log.size(), 2);
    chk(done_cyc == 12, "stall_done", done_cyc, 12);

`ifndef FETCH_BOUND_CHECK_EN
    // address wrap
    expect_fetch(1022, 4);
    do_start(1022, 4);
    wait_end();
    check_timing(4);
    chk(rd_log.size() == 4 && rd_log[0] == 10'd1022
        && rd_log[1] == 10'd1023 && rd_log[2] == 10'd0
        && rd_log[3] == 10'd1, "wrap_addrs", rd_log.size(), 4);

    // wr_limit ignored
    wr_limit = 10'd10;
    expect_fetch(8, 3);
    do_start(8, 3);
    wait_end();
    check_timing(3);
    chk(err_cyc == -1, "no_error", err_cyc, -1);
    wr_limit = 10'd1023;
`else
    // past the write pointer even at the top of the buffer
    exp_err = 1;
    do_start(1022, 4);
    wait_end();
    chk(err_cyc == 1 && rd_cnt == 0, "wrap_rejected", err_cyc, 1);

    wr_limit = 10'd10;
    exp_err = 1;
    do_start(8, 3);
    wait_end();
    chk(err_cyc == 1, "bound_err_cycle", err_cyc, 1);
    chk(rd_cnt == 0, "bound_no_reads", rd_cnt, 0);
    chk(busy_log.size() >= 2 && busy_log[1] == 1'b0, "bound_busy_low",
        busy_log.size(), 2);
    expect_fetch(7, 3);
    do_start(7, 3);
    wait_end();
    check_timing(3);
    chk(err_cyc == -1, "bound_edge_pass", err_cyc, -1);
    wr_limit = 10'd1023;
`endif

    // start_in while busy must be ignored
    expect_fetch(200, 2);
    do_start(200, 2);
    repeat (2) @(negedge clk);
    start_in  = 1'b1;
    base_addr = 10'd500;
    count     = 11'd1;
    repeat (3) @(negedge clk);
    start_in = 1'b0;
    wait_end();
    check_timing(2);

    // reset during WAIT of the second token
    expect_fetch(4, 3);
    do_start(4, 3);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk({ram_rd_en, fifo_wr_en, busy_out, done_out, error_out} == 5'b0
        && ram_rd_addr == '0 && output_token == '0, "async_reset",
        {ram_rd_en, fifo_wr_en, busy_out, done_out, error_out}, 0);
    exp_addr.delete();
    exp_tok.delete();
    exp_done = 0;
    rd_cnt = 0;
    done_cyc = -1;
    wr_cyc.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    chk(rd_cnt == 0 && wr_cyc.size() == 0 && done_cyc == -1,
        "abort_quiet", rd_cnt + wr_cyc.size(), 0);
    expect_fetch(100, 2);
    do_start(100, 2);
    wait_end();
    check_timing(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fetch_controller.md
MEM_FETCH_CONTROLLER -- requirements
Module: mem_fetch_controller

Interface
REQ-001 SHALL have parameter word_size, default 16, token width W.
REQ-002 SHALL have parameter buffer_size, default 1024, RAM/FIFO depth; A = log2(buffer_size) using the codebase log2 rule (log2(1)=1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_in  input  1  fetch request, sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  A  first RAM address, sampled with start_in.
REQ-007 SHALL have port count  input  A+1  tokens to fetch (0..buffer_size), sampled with start_in.
REQ-008 SHALL have port wr_limit  input  A  current RAM write pointer from the write-side controller; used only by the bound check.
REQ-009 SHALL have port ram_rd_data  input  W  RAM read data, valid the cycle after ram_rd_en.
REQ-010 SHALL have port fifo_free  input  A+1  free slots in the output FIFO.
REQ-011 SHALL have port ram_rd_en  output  1  RAM read strobe.
REQ-012 SHALL have port ram_rd_addr  output  A  RAM read address.
REQ-013 SHALL have port fifo_wr_en  output  1  output FIFO write strobe, one cycle per token.
REQ-014 SHALL have port output_token  output  W  registered token presented with fifo_wr_en.
REQ-015 SHALL have port busy_out  output  1  high in every state except IDLE.
REQ-016 SHALL have port done_out  output  1  one-cycle completion pulse.
REQ-017 SHALL have port error_out  output  1  one-cycle bound-violation pulse.

Function
REQ-018 SHALL implement the states IDLE, READ, WAIT, WRITE, DONE and ERR.
REQ-019 IDLE SHALL go, on start_in=1, to DONE if count=0, else to ERR if the bound check fails, else to READ, latching base_addr into addr and count into remaining.
REQ-020 READ SHALL assert ram_rd_en with ram_rd_addr=addr and go to WAIT only when fifo_free>=1; otherwise it SHALL stall in READ with ram_rd_en=0.
REQ-021 WAIT SHALL capture ram_rd_data into output_token at the clock edge that leaves WAIT, then go to WRITE.
REQ-022 WRITE SHALL assert fifo_wr_en for exactly one cycle, decrement remaining and set addr=(addr+1) mod buffer_size, then go to DONE if remaining was 1, else to READ.
REQ-023 DONE SHALL assert done_out for one cycle, then go to IDLE; ERR SHALL assert error_out for one cycle, then go to IDLE.
REQ-024 With no stalls, the first fifo_wr_en SHALL occur 3 cycles after the edge sampling start_in, and done_out SHALL occur 3N+1 cycles after it.
REQ-025 start_in SHALL be ignored whenever state is not IDLE.
REQ-026 At most one read SHALL be in flight; the block is the FIFO's sole writer, so fifo_free>=1 at READ guarantees the WRITE never overflows.
REQ-027 output_token SHALL hold its last value outside WRITE; ram_rd_addr SHALL equal addr in all states.

Reset
REQ-028 rst=0 SHALL immediately, independent of clk, force state to IDLE, addr to 0 and remaining to 0, and clear ram_rd_en, ram_rd_addr, fifo_wr_en, output_token, busy_out, done_out and error_out.
REQ-029 Reset asserted mid-fetch SHALL abort the fetch with no further RAM reads or FIFO writes, and no done_out pulse SHALL follow.

Configuration
REQ-030 With FETCH_BOUND_CHECK_EN defined, the bound check SHALL fail when base_addr+count > wr_limit, computed at A+2 bits with no wrap, and a failing request SHALL produce no RAM reads.
REQ-031 Without FETCH_BOUND_CHECK_EN defined, the check SHALL always pass, ERR SHALL be unreachable, error_out SHALL be tied to 0, wr_limit SHALL be ignored, and addresses SHALL wrap modulo buffer_size.

Structure
REQ-032 The state encodings (3-bit localparams) and the log2 function SHALL live in the shared package pea_pkg, which the write-side controller also uses.
REQ-033 The design SHALL be a single module with no sub-modules; the addr/remaining counters and the FSM SHALL stay inline.

Verification
REQ-034 Bench SHALL cover: base=4, count=3, fifo_free=16, RAM[4..6]=A1,B2,C3 -> fifo_wr_en at cycles 3,6,9 with tokens A1,B2,C3 and done_out at cycle 10.
REQ-035 Bench SHALL cover: count=0 -> done_out at cycle 1, with no ram_rd_en and no fifo_wr_en.
REQ-036 Bench SHALL cover: fifo_free=0 for 5 cycles in READ -> ram_rd_en stays low; after fifo_free=1, the read follows on the next cycle and the token is written intact.
REQ-037 Bench SHALL cover: base=1022, count=4, macro undefined -> reads at addresses 1022, 1023, 0, 1 in order.
REQ-038 Bench SHALL cover: macro defined, wr_limit=10, base=8, count=3 -> error_out pulse at cycle 1, no reads, busy_out low at cycle 2.
REQ-039 Bench SHALL cover: rst pulsed low during WAIT of the second token -> all outputs go to 0 asynchronously, then a new start performs a clean fetch.
